mspeckey_iter: RTL and testbench
================================

Name: mspeckey_iter

Overview:
- Iterative, parametrised Speck-style round engine for the white-box mSPECKEY datapath. Successor to the single combinational keyless 8-bit round.
- Performs ROUNDS rounds on one 2*WORD_W state, one round per clock, with per-round key injection and an encrypt/decrypt mode.
- Valid/ready handshake on both sides, so it drops into the streaming table-generation and encoding pipeline.

Parameters:
- WORD_W, 8, half-state word width in bits; state is 2*WORD_W, with x = upper word and y = lower word.
- ROT_A, 7, right-rotate amount applied to x in the encrypt round; legal range 1..WORD_W-1.
- ROT_B, 2, left-rotate amount applied to y in the encrypt round; legal range 1..WORD_W-1.
- ROUNDS, 4, number of rounds per block; must be >= 1. Round counter width is clog2(ROUNDS+1).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input block valid.
- in_ready  out  1  engine can accept a block.
- in_dec  in  1  mode: 0 = encrypt, 1 = decrypt; sampled on acceptance.
- state_2D_in  in  2*WORD_W  input block {x,y}.
- key_in  in  ROUNDS*WORD_W  round keys; key_in[r*WORD_W +: WORD_W] is the encrypt key of round r.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- state_2D_out  out  2*WORD_W  result block {x,y}.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE and the round counter clears to 0.
  - x/y, key and mode registers clear.
  - Output values: in_ready=1, out_valid=0, busy=0, state_2D_out=0.
  - Reset mid-RUN or mid-DONE discards the block; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch state_2D_in, key_in and in_dec; counter=0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle applies one round to the x/y registers and increments the counter.
  - When the round with counter=ROUNDS-1 completes, go to DONE.
  - in_valid is ignored in this state; inputs are not re-sampled.
- DONE:
  - out_valid=1; state_2D_out = {x,y}, held stable while out_ready=0.
  - On out_ready: go to IDLE with out_valid=0 on the next cycle.
  - in_ready stays 0 in DONE, so a result handshake and an input acceptance never occur in the same cycle.
- Latency: from the acceptance edge, out_valid rises after exactly ROUNDS further edges. Minimum block period is ROUNDS+2 cycles.
- Arithmetic: all operations are modulo 2^WORD_W. Add/subtract wrap silently; no carry out is kept.
- Encrypt round r, with k = key r:
  - x' = (rotr(x,ROT_A) + y) ^ k
  - y' = rotl(y,ROT_B) ^ x'
- Decrypt step r, with k = key (ROUNDS-1-r):
  - y' = rotr(x ^ y, ROT_B)
  - x' = rotl((x ^ k) - y', ROT_A)
- Decrypt with the same keys exactly inverts encrypt for any input.
- With key=0, WORD_W=8, ROT_A=7, ROT_B=2 and ROUNDS=1, encrypt is bit-identical to the existing mSPECKEY_enc round:
  - x' = rotl(x,1) + y
  - y' = rotl(y,2) ^ x'
- state_2D_out is registered and has no combinational path from any input.

Test Plan:
- Single round (ROUNDS=1, key=0x00, enc, in=0x0102) -> out_valid one edge after acceptance, state_2D_out=0x040C. Decrypt of 0x040C with key 0x00 -> 0x0102.
- Two rounds (ROUNDS=2, keys=0x00,0x00, enc, in=0x0102) -> 0x1424 after 2 edges; decrypt of 0x1424 -> 0x0102.
- Key and wrap (ROUNDS=1): key=0xFF, in=0x0102 -> 0xFBF3. key=0x00, in=0xFF01 -> 0x0004 (addition wraps FF+01=00).
- Backpressure (ROUNDS=4, random key/data): hold out_ready=0 for 10 cycles -> out_valid and data stay stable, in_ready=0 throughout. A new in_valid pulse during RUN/DONE is not accepted. After out_ready, in_ready returns 1 the next cycle.
- Reset mid-operation: assert rst_n=0 two cycles into RUN -> outputs immediately 0, in_ready=1. The next block after reset produces the correct result with no residue.
- Round trip (ROUNDS=4 and WORD_W=16, ROT_A=7, ROT_B=2): 1000 random blocks and keys, encrypt then decrypt -> always equals the original block; every block's latency is exactly ROUNDS edges.

Source files
------------

// File: rtl/mspeckey_iter.sv
// mspeckey_iter: iterative Speck-style round engine, one round per clock.
//   Accepts a 2*WORD_W block {x,y} plus ROUNDS round keys on a valid/ready
//   handshake. It runs ROUNDS encrypt rounds or ROUNDS decrypt steps, then
//   holds the result until the downstream side accepts it.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        input handshake; in_ready is high only in IDLE
//   in_dec                   0 = encrypt, 1 = decrypt (latched on acceptance)
//   state_2D_in, key_in      input block and round keys (key r at [r*WORD_W +: WORD_W])
//   out_valid/out_ready      output handshake; out_valid is high only in DONE
//   state_2D_out             registered result block {x,y}
//   busy                     high in RUN or DONE
module mspeckey_iter #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ROT_A  = 7,
  parameter int unsigned ROT_B  = 2,
  parameter int unsigned ROUNDS = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_dec,
  input  logic [2*WORD_W-1:0]        state_2D_in,
  input  logic [ROUNDS*WORD_W-1:0]   key_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [2*WORD_W-1:0]        state_2D_out,
  output logic                       busy
);

  localparam int unsigned CntW = $clog2(ROUNDS + 1);

  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic word_t rotr(input word_t v, input int unsigned n);
    return (v >> n) | (v << (WORD_W - n));
  endfunction

  function automatic word_t rotl(input word_t v, input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  word_t                      x_q, x_d, y_q, y_d;
  logic [ROUNDS*WORD_W-1:0]   key_q, key_d;
  logic                       dec_q, dec_d;

  // Decrypt walks the key schedule backwards.
  logic [CntW-1:0] key_idx;
  word_t           rk;
  assign key_idx = dec_q ? (CntW'(ROUNDS - 1) - cnt_q) : cnt_q;

  always_comb begin
    rk = '0;
    for (int unsigned r = 0; r < ROUNDS; r++) begin
      if (key_idx == CntW'(r)) rk = key_q[r*WORD_W +: WORD_W];
    end
  end

  word_t enc_x, enc_y, dec_x, dec_y;
  assign enc_x = (rotr(x_q, ROT_A) + y_q) ^ rk;
  assign enc_y = rotl(y_q, ROT_B) ^ enc_x;
  assign dec_y = rotr(x_q ^ y_q, ROT_B);
  assign dec_x = rotl((x_q ^ rk) - dec_y, ROT_A);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    key_d   = key_q;
    dec_d   = dec_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          x_d     = state_2D_in[2*WORD_W-1:WORD_W];
          y_d     = state_2D_in[WORD_W-1:0];
          key_d   = key_in;
          dec_d   = in_dec;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d   = dec_q ? dec_x : enc_x;
        y_d   = dec_q ? dec_y : enc_y;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(ROUNDS - 1)) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = (state_q == StDone);
  assign busy         = (state_q != StIdle);
  assign state_2D_out = {x_q, y_q};

endmodule

// File: tb/tb_mspeckey_iter.sv
// Bench for mspeckey_iter: three configurations (W8/R1, W8/R2, W16/R4),
// fixed vectors, random checks against a plain-arithmetic model, backpressure
// and reset-mid-run sequences.
module tb_mspeckey_iter;

  logic clk, rst_n;

  logic a_valid, a_ready, a_dec, a_ovalid, a_oready, a_busy;
  logic [15:0] a_in, a_out;
  logic [7:0]  a_key;

  logic b_valid, b_ready, b_dec, b_ovalid, b_oready, b_busy;
  logic [15:0] b_in, b_out;
  logic [15:0] b_key;

  logic c_valid, c_ready, c_dec, c_ovalid, c_oready, c_busy;
  logic [31:0] c_in, c_out;
  logic [63:0] c_key;

  int checks = 0;
  int errors = 0;

  mspeckey_iter #(.WORD_W(8), .ROT_A(7), .ROT_B(2), .ROUNDS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_valid), .in_ready(a_ready), .in_dec(a_dec),
    .state_2D_in(a_in), .key_in(a_key), .out_valid(a_ovalid), .out_ready(a_oready),
    .state_2D_out(a_out), .busy(a_busy)
  );

  mspeckey_iter #(.WORD_W(8), .ROT_A(7), .ROT_B(2), .ROUNDS(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_ready), .in_dec(b_dec),
    .state_2D_in(b_in), .key_in(b_key), .out_valid(b_ovalid), .out_ready(b_oready),
    .state_2D_out(b_out), .busy(b_busy)
  );

  mspeckey_iter #(.WORD_W(16), .ROT_A(7), .ROT_B(2), .ROUNDS(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_valid), .in_ready(c_ready), .in_dec(c_dec),
    .state_2D_in(c_in), .key_in(c_key), .out_valid(c_ovalid), .out_ready(c_oready),
    .state_2D_out(c_out), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] v, input int unsigned n,
                                     input int unsigned w);
    logic [31:0] m = (32'h1 << w) - 1;
    return ((v >> n) | (v << (w - n))) & m;
  endfunction

  function automatic logic [31:0] rl(input logic [31:0] v, input int unsigned n,
                                     input int unsigned w);
    return rr(v, w - n, w);
  endfunction

  // Reference: straight from the round equations, words held in plain integers.
  function automatic logic [31:0] model(input int unsigned w, input int unsigned ra,
                                        input int unsigned rb, input int unsigned rounds,
                                        input bit dec, input logic [31:0] blk,
                                        input logic [63:0] keys);
    logic [31:0] m = (32'h1 << w) - 1;
    logic [31:0] x = (blk >> w) & m;
    logic [31:0] y = blk & m;
    logic [31:0] k;
    for (int r = 0; r < int'(rounds); r++) begin
      if (!dec) begin
        k = 32'((keys >> (r * w))) & m;
        x = ((rr(x, ra, w) + y) & m) ^ k;
        y = rl(y, rb, w) ^ x;
      end else begin
        k = 32'((keys >> ((int'(rounds) - 1 - r) * w))) & m;
        y = rr(x ^ y, rb, w);
        x = rl(((x ^ k) - y) & m, ra, w);
      end
    end
    return (x << w) | y;
  endfunction

  task automatic xact_a(input bit dec, input logic [15:0] din, input logic [7:0] k,
                        output logic [15:0] res, output int lat);
    a_dec = dec; a_in = din; a_key = k; a_valid = 1'b1;
    @(posedge clk); #1; a_valid = 1'b0; lat = 0;
    while (!a_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = a_out;
    a_oready = 1'b1; @(posedge clk); #1; a_oready = 1'b0;
  endtask

  task automatic xact_b(input bit dec, input logic [15:0] din, input logic [15:0] k,
                        output logic [15:0] res, output int lat);
    b_dec = dec; b_in = din; b_key = k; b_valid = 1'b1;
    @(posedge clk); #1; b_valid = 1'b0; lat = 0;
    while (!b_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = b_out;
    b_oready = 1'b1; @(posedge clk); #1; b_oready = 1'b0;
  endtask

  task automatic xact_c(input bit dec, input logic [31:0] din, input logic [63:0] k,
                        output logic [31:0] res, output int lat);
    c_dec = dec; c_in = din; c_key = k; c_valid = 1'b1;
    @(posedge clk); #1; c_valid = 1'b0; lat = 0;
    while (!c_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
    res = c_out;
    c_oready = 1'b1; @(posedge clk); #1; c_oready = 1'b0;
  endtask

  typedef struct {
    int          rounds;
    bit          dec;
    logic [15:0] din;
    logic [15:0] key;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] r16;
    logic [31:0] r32, d32, e32, exp32;
    logic [63:0] k64;
    logic [7:0]  k8;
    bit          dec;
    int          lat;

    vecs[0] = '{1, 1'b0, 16'h0102, 16'h0000, 16'h040C};
    vecs[1] = '{1, 1'b1, 16'h040C, 16'h0000, 16'h0102};
    vecs[2] = '{2, 1'b0, 16'h0102, 16'h0000, 16'h1424};
    vecs[3] = '{2, 1'b1, 16'h1424, 16'h0000, 16'h0102};
    vecs[4] = '{1, 1'b0, 16'h0102, 16'h00FF, 16'hFBF3};
    vecs[5] = '{1, 1'b0, 16'hFF01, 16'h0000, 16'h0004};

    rst_n = 1'b0;
    a_valid = 0; a_dec = 0; a_oready = 0; a_in = '0; a_key = '0;
    b_valid = 0; b_dec = 0; b_oready = 0; b_in = '0; b_key = '0;
    c_valid = 0; c_dec = 0; c_oready = 0; c_in = '0; c_key = '0;
    #2;
    chk("reset in_ready", {a_ready, b_ready, c_ready}, 3'b111);
    chk("reset out_valid", {a_ovalid, b_ovalid, c_ovalid}, 3'b000);
    chk("reset busy", {a_busy, b_busy, c_busy}, 3'b000);
    chk("reset data", {a_out, b_out, c_out}, 64'h0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Fixed vectors
    foreach (vecs[i]) begin
      if (vecs[i].rounds == 1) xact_a(vecs[i].dec, vecs[i].din, vecs[i].key[7:0], r16, lat);
      else                     xact_b(vecs[i].dec, vecs[i].din, vecs[i].key, r16, lat);
      chk($sformatf("vec%0d data", i), r16, vecs[i].exp);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].rounds);
    end
    chk("a in_ready after handshake", a_ready, 1'b1);
    chk("b in_ready after handshake", b_ready, 1'b1);

    // Random single-round and two-round blocks against the model
    for (int i = 0; i < 40; i++) begin
      dec = 1'($urandom_range(0, 1));
      r16 = 16'($urandom); k8 = 8'($urandom);
      xact_a(dec, r16, k8, r32[15:0], lat);
      chk("a random data", r32[15:0], model(8, 7, 2, 1, dec, {16'h0, r16}, {56'h0, k8}));
      r16 = 16'($urandom); k64 = {48'h0, 16'($urandom)};
      xact_b(dec, r16, k64[15:0], r32[15:0], lat);
      chk("b random data", r32[15:0], model(8, 7, 2, 2, dec, {16'h0, r16}, k64));
    end

    // Backpressure with in_valid pulses during RUN and DONE
    d32 = $urandom; k64 = {$urandom, $urandom};
    exp32 = model(16, 7, 2, 4, 1'b0, d32, k64);
    c_dec = 1'b0; c_in = d32; c_key = k64; c_valid = 1'b1;
    @(posedge clk); #1;
    c_in = ~d32; c_dec = 1'b1;
    chk("bp in_ready in run", c_ready, 1'b0);
    @(posedge clk); #1; c_valid = 1'b0; lat = 1;
    while (!c_ovalid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      chk("bp out_valid held", c_ovalid, 1'b1);
      chk("bp data held", c_out, exp32);
      chk("bp in_ready low", c_ready, 1'b0);
      c_valid = (i == 3); c_in = $urandom;
      @(posedge clk); #1;
    end
    c_valid = 1'b0;
    c_oready = 1'b1; @(posedge clk); #1; c_oready = 1'b0;
    chk("bp in_ready after release", c_ready, 1'b1);
    chk("bp out_valid after release", c_ovalid, 1'b0);
    @(posedge clk); #1;
    chk("bp no stray acceptance", c_busy, 1'b0);

    // Reset two cycles into RUN
    c_dec = 1'b0; c_in = $urandom; c_key = {$urandom, $urandom}; c_valid = 1'b1;
    @(posedge clk); #1; c_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre-reset busy", c_busy, 1'b1);
    rst_n = 1'b0; #1;
    chk("mid reset out_valid", c_ovalid, 1'b0);
    chk("mid reset in_ready", c_ready, 1'b1);
    chk("mid reset busy", c_busy, 1'b0);
    chk("mid reset data", c_out, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    d32 = $urandom; k64 = {$urandom, $urandom};
    xact_c(1'b0, d32, k64, e32, lat);
    chk("post-reset data", e32, model(16, 7, 2, 4, 1'b0, d32, k64));
    chk("post-reset latency", lat, 4);

    // Round trip, W16/R4
    for (int i = 0; i < 1000; i++) begin
      d32 = $urandom; k64 = {$urandom, $urandom};
      xact_c(1'b0, d32, k64, e32, lat);
      chk("rt enc data", e32, model(16, 7, 2, 4, 1'b0, d32, k64));
      chk("rt enc latency", lat, 4);
      xact_c(1'b1, e32, k64, r32, lat);
      chk("rt dec data", r32, d32);
      chk("rt dec latency", lat, 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
